// File: rtl/morse_beeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | morse_beeper: Morse slot sequencer driving a square-wave buzzer output.  |
// | Optional loop mode: define MORSE_BEEP_REPEAT_EN.           Revision 1.0  |
// +--------------------------------------------------------------------------+
module morse_beeper #(
   parameter int MAX_BITS  = 75,
   parameter int LEN_W     = 7,
   parameter int UNIT_CYC  = 20_000_000,
   parameter int TONE_HALF = 50_000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_start,
   input  logic                i_stop,
   input  logic [MAX_BITS-1:0] i_pattern,
   input  logic [LEN_W-1:0]    i_len,
`ifdef MORSE_BEEP_REPEAT_EN
   input  logic                i_repeat,
`endif
   output logic                o_busy,
   output logic                o_done,
   output logic [LEN_W-1:0]    o_bit_idx,
   output logic                o_beep
);

   localparam int c_UNIT_W = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
   localparam int c_TONE_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
   localparam logic [c_UNIT_W-1:0] c_UNIT_LAST = c_UNIT_W'(UNIT_CYC - 1);
   localparam logic [c_TONE_W-1:0] c_TONE_LAST = c_TONE_W'(TONE_HALF - 1);
   localparam logic [LEN_W-1:0]    c_MAX_LEN   = LEN_W'(MAX_BITS);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_PLAY = 1'b1
   } state_t;

   state_t              r_state;
   logic [MAX_BITS-1:0] r_pat;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    r_bit_idx;
   logic [c_UNIT_W-1:0] r_unit_cnt;
   logic [c_TONE_W-1:0] r_tone_cnt;
   logic                r_tone;
   logic                r_busy;
   logic                r_done;

   logic                w_repeat;
   logic                w_len_ok;
   logic                w_unit_end;
   logic                w_last_slot;
   logic [MAX_BITS-1:0] w_pat_sh;

`ifdef MORSE_BEEP_REPEAT_EN
   assign w_repeat = i_repeat;
`else
   assign w_repeat = 1'b0;
`endif

   assign w_len_ok    = (i_len != '0) && (i_len <= c_MAX_LEN);
   assign w_unit_end  = (r_unit_cnt == c_UNIT_LAST);
   assign w_last_slot = (r_bit_idx == (r_len - LEN_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_pat      <= '0;
         r_len      <= '0;
         r_bit_idx  <= '0;
         r_unit_cnt <= '0;
         r_tone_cnt <= '0;
         r_tone     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  if (w_len_ok) begin
                     r_pat      <= i_pattern;
                     r_len      <= i_len;
                     r_bit_idx  <= '0;
                     r_unit_cnt <= '0;
                     r_tone_cnt <= '0;
                     r_tone     <= 1'b1;
                     r_busy     <= 1'b1;
                     r_state    <= S_PLAY;
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            S_PLAY: begin
               if (i_stop) begin
                  // Abort beats a coinciding end-of-pattern, so no done here.
                  r_state    <= S_IDLE;
                  r_busy     <= 1'b0;
                  r_bit_idx  <= '0;
                  r_unit_cnt <= '0;
                  r_tone_cnt <= '0;
                  r_tone     <= 1'b0;
               end else begin
                  if (r_tone_cnt == c_TONE_LAST) begin
                     r_tone_cnt <= '0;
                     r_tone     <= ~r_tone;
                  end else begin
                     r_tone_cnt <= r_tone_cnt + c_TONE_W'(1);
                  end

                  if (w_unit_end) begin
                     r_unit_cnt <= '0;
                     if (w_last_slot) begin
                        r_bit_idx <= '0;
                        if (!w_repeat) begin
                           r_state    <= S_IDLE;
                           r_busy     <= 1'b0;
                           r_done     <= 1'b1;
                           r_tone_cnt <= '0;
                           r_tone     <= 1'b0;
                        end
                     end else begin
                        r_bit_idx <= r_bit_idx + LEN_W'(1);
                     end
                  end else begin
                     r_unit_cnt <= r_unit_cnt + c_UNIT_W'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Shift rather than index so slot indices past MAX_BITS read as silent.
   assign w_pat_sh  = r_pat >> r_bit_idx;

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_bit_idx = r_bit_idx;
   assign o_beep    = r_busy & r_tone & w_pat_sh[0];

endmodule
`default_nettype wire

// File: tb/tb_morse_beeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_morse_beeper: vector table plus randomized runs against a slot model. |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_morse_beeper;

   localparam int MAXB = 75;
   localparam int LW   = 7;
   localparam int U    = 8;
   localparam int TH   = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            i_start;
   logic            i_stop;
   logic [MAXB-1:0] i_pattern;
   logic [LW-1:0]   i_len;
   logic            i_repeat;
   logic            o_busy;
   logic            o_done;
   logic [LW-1:0]   o_bit_idx;
   logic            o_beep;

   int n_err = 0;
   int n_chk = 0;

   morse_beeper #(
      .MAX_BITS (MAXB),
      .LEN_W    (LW),
      .UNIT_CYC (U),
      .TONE_HALF(TH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (i_start),
      .i_stop   (i_stop),
      .i_pattern(i_pattern),
      .i_len    (i_len),
`ifdef MORSE_BEEP_REPEAT_EN
      .i_repeat (i_repeat),
`endif
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_bit_idx(o_bit_idx),
      .o_beep   (o_beep)
   );

   always #5 clk = ~clk;

   typedef struct {
      string           nm;
      int              len;
      logic [MAXB-1:0] pat;
      int              stop_at;
      int              exp_busy;
      int              exp_done;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s t=%0d: got %0d expected %0d", nm, t, act, exp);
      end
   endtask

   // Expected outputs t edges after the start edge, from slot arithmetic.
   function automatic void model(input int len, input logic [MAXB-1:0] pat, input int stop_at,
                                 input int t, output logic busy, output logic done,
                                 output logic beep, output int idx);
      int  end_t;
      logic tone;
      busy = 1'b0; done = 1'b0; beep = 1'b0; idx = 0;
      end_t = len * U;
      tone  = ((t / TH) % 2) == 0;
      if (len < 1 || len > MAXB) begin
         done = (t == 0);
      end else if (stop_at >= 0 && t > stop_at) begin
         busy = 1'b0;
      end else if (t < end_t) begin
         busy = 1'b1;
         idx  = t / U;
         beep = tone & pat[idx];
      end else if (t == end_t) begin
         done = 1'b1;
      end
   endfunction

   task automatic check_at(input string nm, input int len, input logic [MAXB-1:0] pat,
                           input int stop_at, input int t);
      logic eb, ed, ebp;
      int   ei;
      model(len, pat, stop_at, t, eb, ed, ebp, ei);
      chk({nm, ".busy"}, t, 32'(o_busy), 32'(eb));
      chk({nm, ".done"}, t, 32'(o_done), 32'(ed));
      chk({nm, ".bit_idx"}, t, 32'(o_bit_idx), 32'(ei));
      chk({nm, ".beep"}, t, 32'(o_beep), 32'(ebp));
   endtask

   task automatic run_case(input vec_t v, output int busy_n, output int done_n);
      int end_t, play_last;
      bit valid;
      valid     = (v.len >= 1) && (v.len <= MAXB);
      end_t     = valid ? v.len * U : 0;
      play_last = !valid ? -1 : (v.stop_at >= 0 ? v.stop_at + 1 : end_t);
      busy_n    = 0;
      done_n    = 0;
      i_start   = 1'b1;
      i_stop    = 1'b0;
      i_len     = LW'(v.len);
      i_pattern = v.pat;
      tick();
      for (int t = 0; t <= end_t + 2; t++) begin
         check_at(v.nm, v.len, v.pat, v.stop_at, t);
         busy_n += int'(o_busy);
         done_n += int'(o_done);
         if (t + 1 <= play_last) begin
            // Noise on start/pattern/len while playing must be ignored.
            i_start   = 1'($urandom_range(0, 1));
            i_pattern = MAXB'({$urandom(), $urandom(), $urandom()});
            i_len     = LW'($urandom());
            i_stop    = (t == v.stop_at);
         end else begin
            i_start   = 1'b0;
            i_stop    = 1'($urandom_range(0, 1));
         end
         tick();
      end
      i_start = 1'b0;
      i_stop  = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t            vecs[$];
      vec_t            v;
      int              bn, dn;
      logic [MAXB-1:0] ones;

      ones = '1;
      vecs.push_back('{"tp_101",   3,  MAXB'(3'b101), -1, 24, 1});
      vecs.push_back('{"len0",     0,  ones,          -1, 0,  1});
      vecs.push_back('{"len76",    76, ones,          -1, 0,  1});
      vecs.push_back('{"len127",   127, ones,         -1, 0,  1});
      vecs.push_back('{"stop10",   4,  ones,          10, 11, 0});
      vecs.push_back('{"replay",   4,  ones,          -1, 32, 1});
      vecs.push_back('{"len1",     1,  MAXB'(1),      -1, 8,  1});
      vecs.push_back('{"stop_end", 2,  ones,          15, 16, 0});
      vecs.push_back('{"len_max",  MAXB, MAXB'({$urandom(), $urandom(), $urandom()}), -1, MAXB * U, 1});
      for (int i = 0; i < 4; i++) begin
         v.nm       = "rand";
         v.len      = int'($urandom_range(1, 6));
         v.pat      = MAXB'({$urandom(), $urandom(), $urandom()});
         v.stop_at  = -1;
         v.exp_busy = v.len * U;
         v.exp_done = 1;
         vecs.push_back(v);
      end

      rst_n     = 1'b0;
      i_start   = 1'b0;
      i_stop    = 1'b0;
      i_pattern = '0;
      i_len     = '0;
      i_repeat  = 1'b0;
      #12;
      chk("reset.busy", 0, 32'(o_busy), 0);
      chk("reset.done", 0, 32'(o_done), 0);
      chk("reset.bit_idx", 0, 32'(o_bit_idx), 0);
      chk("reset.beep", 0, 32'(o_beep), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("idle.busy", 0, 32'(o_busy), 0);

      foreach (vecs[i]) begin
         run_case(vecs[i], bn, dn);
         chk({vecs[i].nm, ".busy_cycles"}, 0, 32'(bn), 32'(vecs[i].exp_busy));
         chk({vecs[i].nm, ".done_pulses"}, 0, 32'(dn), 32'(vecs[i].exp_done));
      end

      // Restart accepted in the very cycle done is high.
      i_start = 1'b1; i_len = 7'd1; i_pattern = MAXB'(1);
      tick();
      for (int t = 0; t <= U; t++) begin
         check_at("b2b_a", 1, MAXB'(1), -1, t);
         i_start   = (t == U);
         i_len     = 7'd2;
         i_pattern = MAXB'(2'b10);
         tick();
      end
      i_start = 1'b0;
      for (int t = 0; t <= 2 * U + 1; t++) begin
         check_at("b2b_b", 2, MAXB'(2'b10), -1, t);
         tick();
      end

      // Asynchronous reset in the middle of a sounding slot.
      i_start = 1'b1; i_len = 7'd4; i_pattern = ones;
      tick();
      i_start = 1'b0;
      repeat (5) tick();
      chk("areset.pre_busy", 5, 32'(o_busy), 1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("areset.busy", 0, 32'(o_busy), 0);
      chk("areset.beep", 0, 32'(o_beep), 0);
      chk("areset.done", 0, 32'(o_done), 0);
      chk("areset.bit_idx", 0, 32'(o_bit_idx), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("areset.after_done", 0, 32'(o_done), 0);
      chk("areset.after_busy", 0, 32'(o_busy), 0);

`ifdef MORSE_BEEP_REPEAT_EN
      begin
         int dcount;
         dcount   = 0;
         i_repeat = 1'b1;
         i_start  = 1'b1; i_len = 7'd2; i_pattern = MAXB'(2'b11);
         tick();
         i_start = 1'b0;
         for (int t = 0; t <= 6 * U + 1; t++) begin
            if (t < 6 * U) begin
               chk("rep.bit_idx", t, 32'(o_bit_idx), 32'((t / U) % 2));
               chk("rep.busy", t, 32'(o_busy), 1);
               chk("rep.beep", t, 32'(o_beep), 32'(((t / TH) % 2) == 0));
            end else begin
               chk("rep.end_busy", t, 32'(o_busy), 0);
            end
            chk("rep.done", t, 32'(o_done), 32'(t == 6 * U));
            dcount += int'(o_done);
            if (t == 4 * U + 3) i_repeat = 1'b0;
            tick();
         end
         chk("rep.done_pulses", 0, 32'(dcount), 1);
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
